// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM state encoding for the two-requester shared FP multiplier.
package fp_mul_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_main.sv
// Combinational IEEE-754 single-precision multiplier: truncating, zero-exponent inputs
// treated as zero, overflow saturates to infinity, underflow flushes to signed zero.
module mul_main (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] m,
  output logic        overflow,
  output logic        underflow
);
  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [23:0]       ma;
  logic [23:0]       mb;
  logic [47:0]       prod;
  logic              norm;
  logic [22:0]       frac;
  logic signed [9:0] exp_sum;
  logic              zero_in;
  logic              unused_prod_bits;

  always_comb begin
    sign      = a[31] ^ b[31];
    ea        = a[30:23];
    eb        = b[30:23];
    ma        = {1'b1, a[22:0]};
    mb        = {1'b1, b[22:0]};
    zero_in   = (ea == 8'd0) || (eb == 8'd0);
    prod      = {24'd0, ma} * {24'd0, mb};
    norm      = prod[47];
    // Product of two [1,2) mantissas lies in [1,4); renormalise by one bit when >= 2.
    frac      = norm ? prod[46:24] : prod[45:23];
    exp_sum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) + $signed({9'd0, norm}) - 10'sd127;
    m         = {sign, 31'd0};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (zero_in) begin
      m = {sign, 31'd0};
    end else if (exp_sum >= 10'sd255) begin
      m        = {sign, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_sum <= 10'sd0) begin
      m         = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      m = {sign, exp_sum[7:0], frac};
    end
  end

  assign unused_prod_bits = ^prod[22:0];
endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one mul_main between two requesters.
// Handshake: gnt_i pulses in IDLE when operands are captured; out_valid/out_ready transfer on a cycle where both are high.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int DATA_WIDTH = fp_mul_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_m,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  out_id,
  output logic                  busy,
  output state_t                dbg_state
);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [DATA_WIDTH-1:0] out_m_q, out_m_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_unf_q, out_unf_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic                  grant;
  logic [ID_W-1:0]       pick;
  logic [DATA_WIDTH-1:0] mul_m;
  logic                  mul_ovf;
  logic                  mul_unf;

  mul_main u_mul (
    .a         (op_a_q),
    .b         (op_b_q),
    .m         (mul_m),
    .overflow  (mul_ovf),
    .underflow (mul_unf)
  );

  always_comb begin
    // On a tie the requester not served last wins; a lone requester always wins.
    pick      = (req0 && req1) ? ~last_q : req1;
    grant     = (state_q == IDLE) && (req0 || req1);
    gnt0      = grant && (pick == 1'b0);
    gnt1      = grant && (pick == 1'b1);
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    id_d      = id_q;
    last_d    = last_q;
    out_m_d   = out_m_q;
    out_ovf_d = out_ovf_q;
    out_unf_d = out_unf_q;
    out_id_d  = out_id_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          op_a_d  = pick[0] ? a1 : a0;
          op_b_d  = pick[0] ? b1 : b0;
          id_d    = pick;
          last_d  = pick;
          state_d = CALC;
        end
      end
      CALC: begin
        out_m_d   = mul_m;
        out_ovf_d = mul_ovf;
        out_unf_d = mul_unf;
        out_id_d  = id_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      last_q    <= 1'b1;
      out_m_q   <= '0;
      out_ovf_q <= 1'b0;
      out_unf_q <= 1'b0;
      out_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      last_q    <= last_d;
      out_m_q   <= out_m_d;
      out_ovf_q <= out_ovf_d;
      out_unf_q <= out_unf_d;
      out_id_q  <= out_id_d;
    end
  end

  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_m         = out_m_q;
  assign out_overflow  = out_ovf_q;
  assign out_underflow = out_unf_q;
  assign out_id        = out_id_q;
  assign dbg_state     = state_q;
endmodule
